// File: rtl/tft_timing_pkg.sv
// Shared definitions for the TFT raster timing generator.
//   - Default 480x272 panel geometry and sync polarities
//   - Run/stop state enum and the DE/HS/VS control payload
//   - clog2_min1(): counter width that never collapses to zero bits
package tft_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE  = 480;
   localparam int unsigned DEF_H_FP      = 2;
   localparam int unsigned DEF_H_SYNC    = 41;
   localparam int unsigned DEF_H_BP      = 2;
   localparam int unsigned DEF_V_ACTIVE  = 272;
   localparam int unsigned DEF_V_FP      = 2;
   localparam int unsigned DEF_V_SYNC    = 10;
   localparam int unsigned DEF_V_BP      = 2;
   localparam bit          DEF_HS_POL    = 1'b0;
   localparam bit          DEF_VS_POL    = 1'b0;
   localparam int unsigned DEF_LOOKAHEAD = 2;
   localparam int unsigned MAX_LOOKAHEAD = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Panel control levels travelling together through the lookahead delay
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } ctl_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tft_axis_counter.sv
// Wrapping position counter for one raster axis (active, FP, SYNC, BP order).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            advance the count by one
//   count         current position, 0..TOT-1
//   wrap_c        en while count is at TOT-1 (count returns to 0 next)
//   in_active_c   count is inside the active region
//   in_sync_c     count is inside the sync window
module tft_axis_counter
   import tft_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned W      = clog2_min1(ACTIVE + FP + SYNC + BP)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap_c,
   output logic         in_active_c,
   output logic         in_sync_c
);

   localparam int unsigned TOT     = ACTIVE + FP + SYNC + BP;
   localparam int unsigned SYNC_LO = ACTIVE + FP;
   localparam int unsigned SYNC_HI = ACTIVE + FP + SYNC;

   assign wrap_c      = en && (count == W'(TOT - 1));
   assign in_active_c = (count < W'(ACTIVE));
   assign in_sync_c   = (count >= W'(SYNC_LO)) && (count < W'(SYNC_HI));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         count <= '0;
      else if (wrap_c) count <= '0;
      else if (en)     count <= count + W'(1);
   end

endmodule

// File: rtl/tft_lcd_timing_gen.sv
// Parametrised raster timing generator for parallel-RGB TFT panels.
// Ports:
//   in_pix_clk       pixel clock
//   in_rst           asynchronous active-high reset
//   in_run           1 = generate frames, 0 = stop at the end of the current frame
//   out_en           panel data enable, trails coordinates by LOOKAHEAD clocks
//   out_hsync        horizontal sync (active level HS_POL)
//   out_vsync        vertical sync (active level VS_POL)
//   out_pixelx/y     coordinate to fetch, 0 outside the active area
//   out_line_start   strobe with pixelx==0 of each active line
//   out_frame_start  strobe with the line_start of line 0
//   out_clk          panel clock, inverted pixel clock
module tft_lcd_timing_gen
   import tft_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter bit          HS_POL    = DEF_HS_POL,
   parameter bit          VS_POL    = DEF_VS_POL,
   parameter int unsigned LOOKAHEAD = DEF_LOOKAHEAD
) (
   input  logic                             in_pix_clk,
   input  logic                             in_rst,
   input  logic                             in_run,
   output logic                             out_en,
   output logic                             out_hsync,
   output logic                             out_vsync,
   output logic [clog2_min1(H_ACTIVE)-1:0]  out_pixelx,
   output logic [clog2_min1(V_ACTIVE)-1:0]  out_pixely,
   output logic                             out_line_start,
   output logic                             out_frame_start,
   output logic                             out_clk
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW    = clog2_min1(H_TOT);
   localparam int unsigned VW    = clog2_min1(V_TOT);
   localparam int unsigned XW    = clog2_min1(H_ACTIVE);
   localparam int unsigned YW    = clog2_min1(V_ACTIVE);
   localparam ctl_t        CTL_IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

   // Reject geometries with empty porch/sync regions or an over-long lookahead
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geom
      $error("tft_lcd_timing_gen: every porch and sync width must be at least 1");
   end
   if (LOOKAHEAD > MAX_LOOKAHEAD) begin : g_bad_la
      $error("tft_lcd_timing_gen: LOOKAHEAD must be 0..8");
   end

   run_state_e       state, state_nxt;
   logic             run_c;
   logic [HW-1:0]    h_count;
   logic [VW-1:0]    v_count;
   logic             h_wrap_c, h_act_c, h_sync_c;
   logic             v_wrap_c, v_act_c, v_sync_c;
   logic             active_c;
   ctl_t             raw_c, ctl_q, ctl_out;

   tft_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
   ) u_h_cnt (
      .clk(in_pix_clk), .rst(in_rst), .en(run_c),
      .count(h_count), .wrap_c(h_wrap_c), .in_active_c(h_act_c), .in_sync_c(h_sync_c)
   );

   tft_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
   ) u_v_cnt (
      .clk(in_pix_clk), .rst(in_rst), .en(h_wrap_c),
      .count(v_count), .wrap_c(v_wrap_c), .in_active_c(v_act_c), .in_sync_c(v_sync_c)
   );

   // Run/stop state register
   always_ff @(posedge in_pix_clk or posedge in_rst) begin
      if (in_rst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Stop is honoured only on the last clock of a frame (v_wrap_c)
   always_comb begin
      state_nxt = state;
      run_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_run) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            run_c = 1'b1;
            if (!in_run && v_wrap_c) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Raw decode; IDLE parks h=v=0 so everything is gated by run_c
   always_comb begin
      active_c = run_c && h_act_c && v_act_c;
      raw_c.de = active_c;
      raw_c.hs = (run_c && h_sync_c) ? HS_POL : ~HS_POL;
      raw_c.vs = (run_c && v_sync_c) ? VS_POL : ~VS_POL;
   end

   // Coordinates, strobes and raw controls registered one clock after the counters
   always_ff @(posedge in_pix_clk or posedge in_rst) begin
      if (in_rst) begin
         ctl_q           <= CTL_IDLE;
         out_pixelx      <= '0;
         out_pixely      <= '0;
         out_line_start  <= 1'b0;
         out_frame_start <= 1'b0;
      end else begin
         ctl_q           <= raw_c;
         out_pixelx      <= active_c ? XW'(h_count) : '0;
         out_pixely      <= active_c ? YW'(v_count) : '0;
         out_line_start  <= active_c && (h_count == '0);
         out_frame_start <= active_c && (h_count == '0) && (v_count == '0);
      end
   end

   // Delay DE/HS/VS so they trail the coordinates by LOOKAHEAD clocks
   if (LOOKAHEAD == 0) begin : g_no_la
      assign ctl_out = ctl_q;
   end else begin : g_la
      ctl_t sr [LOOKAHEAD];
      always_ff @(posedge in_pix_clk or posedge in_rst) begin
         if (in_rst) begin
            for (int i = 0; i < int'(LOOKAHEAD); i++) sr[i] <= CTL_IDLE;
         end else begin
            sr[0] <= ctl_q;
            for (int i = 1; i < int'(LOOKAHEAD); i++) sr[i] <= sr[i-1];
         end
      end
      assign ctl_out = sr[LOOKAHEAD-1];
   end

   assign out_en    = ctl_out.de;
   assign out_hsync = ctl_out.hs;
   assign out_vsync = ctl_out.vs;

   // Panel samples on its rising edge, mid-way through our data-valid window
   assign out_clk = ~in_pix_clk;

endmodule
